// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command-line parser: command codes, the
// ASCII characters the protocol recognises and the parser FSM state encoding.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_VALUE = 2'd3
  } cmd_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_NUM  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UP_C  = 8'h43;
  localparam logic [7:0] ASCII_UP_R  = 8'h52;
  localparam logic [7:0] ASCII_UP_S  = 8'h53;
  localparam logic [7:0] ASCII_UP_V  = 8'h56;
  localparam logic [7:0] ASCII_LO_C  = 8'h63;
  localparam logic [7:0] ASCII_LO_R  = 8'h72;
  localparam logic [7:0] ASCII_LO_S  = 8'h73;
  localparam logic [7:0] ASCII_LO_V  = 8'h76;

  // Maximum number of operand digits, leading zeros included.
  localparam logic [2:0] MAX_DIGITS  = 3'd4;

endpackage

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Parses single-line ASCII commands "<letter>[digits]<CR|LF>" arriving byte
// by byte from a UART receiver in the same clock domain.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   rx_done   in   one-cycle strobe, rx_data valid
//   rx_data   in   received byte
//   cmd_valid out  one-cycle pulse, well-formed command accepted
//   cmd_code  out  RUN=0 STOP=1 CLEAR=2 VALUE=3, held between pulses
//   cmd_value out  VALUE operand 0..9999 (0 for other codes), held
//   cmd_err   out  one-cycle pulse, malformed line discarded
//   busy      out  high while a line is partially received
// -----------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [1:0]  cmd_code,
  output logic [13:0] cmd_value,
  output logic        cmd_err,
  output logic        busy
);

  state_t      r_state;
  cmd_code_t   r_code;
  logic [13:0] r_acc;
  logic [2:0]  r_digit_cnt;
  logic        r_cmd_valid;
  logic        r_cmd_err;
  cmd_code_t   r_cmd_code;
  logic [13:0] r_cmd_value;

  logic        w_is_term;
  logic        w_is_digit;
  logic        w_is_letter;
  cmd_code_t   w_letter_code;
  logic [13:0] w_digit_val;

  // Byte classification; bytes with bit7 set never match any class.
  always_comb begin
    w_is_term     = 1'b0;
    w_is_digit    = 1'b0;
    w_is_letter   = 1'b1;
    w_letter_code = CMD_RUN;
    w_digit_val   = {10'd0, rx_data[3:0]};
    if ((rx_data == ASCII_CR) || (rx_data == ASCII_LF)) begin
      w_is_term = 1'b1;
    end else begin
      w_is_term = 1'b0;
    end
    if ((rx_data >= ASCII_0) && (rx_data <= ASCII_9)) begin
      w_is_digit = 1'b1;
    end else begin
      w_is_digit = 1'b0;
    end
    case (rx_data)
      ASCII_UP_R, ASCII_LO_R: w_letter_code = CMD_RUN;
      ASCII_UP_S, ASCII_LO_S: w_letter_code = CMD_STOP;
      ASCII_UP_C, ASCII_LO_C: w_letter_code = CMD_CLEAR;
      ASCII_UP_V, ASCII_LO_V: w_letter_code = CMD_VALUE;
      default: begin
        w_letter_code = CMD_RUN;
        w_is_letter   = 1'b0;
      end
    endcase
  end

  // Parser FSM with registered result outputs; only advances on rx_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_code      <= CMD_RUN;
      r_acc       <= 14'd0;
      r_digit_cnt <= 3'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_cmd_code  <= CMD_RUN;
      r_cmd_value <= 14'd0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      if (rx_done) begin
        case (r_state)
          ST_IDLE: begin
            // A bare terminator here is the second half of CR LF: ignore it.
            if (w_is_letter) begin
              r_code  <= w_letter_code;
              r_state <= ST_CMD;
            end else if (!w_is_term) begin
              r_state <= ST_ERR;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_CMD: begin
            if ((r_code == CMD_VALUE) && w_is_digit) begin
              r_acc       <= w_digit_val;
              r_digit_cnt <= 3'd1;
              r_state     <= ST_NUM;
            end else if (w_is_term) begin
              r_state <= ST_IDLE;
              if (r_code == CMD_VALUE) begin
                r_cmd_err <= 1'b1;  // VALUE without operand
              end else begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= r_code;
                r_cmd_value <= 14'd0;
              end
            end else begin
              r_state <= ST_ERR;
            end
          end
          ST_NUM: begin
            if (w_is_digit) begin
              if (r_digit_cnt < MAX_DIGITS) begin
                // At most 999*10+9 = 9999, so 14 bits never overflow.
                r_acc       <= (r_acc * 14'd10) + w_digit_val;
                r_digit_cnt <= r_digit_cnt + 3'd1;
              end else begin
                r_state <= ST_ERR;
              end
            end else if (w_is_term) begin
              r_cmd_valid <= 1'b1;
              r_cmd_code  <= CMD_VALUE;
              r_cmd_value <= r_acc;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_ERR;
            end
          end
          ST_ERR: begin
            if (w_is_term) begin
              r_cmd_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_state <= ST_ERR;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_err   = r_cmd_err;
  assign cmd_code  = r_cmd_code;
  assign cmd_value = r_cmd_value;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed, table-driven bench for uart_cmd_parser. Each table row is one
// clock cycle of input plus the outputs expected right after that edge.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  logic        clk;
  logic        rst;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic [13:0] cmd_value;
  logic        cmd_err;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic        dv;
    logic [7:0]  d;
    logic        v;
    logic        e;
    logic [1:0]  c;
    logic [13:0] val;
    logic        b;
  } vec_t;

  vec_t vecs[$];

  uart_cmd_parser dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_value (cmd_value),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic dv, input logic [7:0] d, input logic v, input logic e,
                     input logic [1:0] c, input logic [13:0] val, input logic b);
    vec_t t;
    t.dv = dv; t.d = d; t.v = v; t.e = e; t.c = c; t.val = val; t.b = b;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic v, input logic e,
                       input logic [1:0] c, input logic [13:0] val, input logic b);
    checks++;
    if ((cmd_valid !== v) || (cmd_err !== e) || (cmd_code !== c) ||
        (cmd_value !== val) || (busy !== b)) begin
      failures++;
      $display("FAIL %s: got valid=%b err=%b code=%0d value=%0d busy=%b, want valid=%b err=%b code=%0d value=%0d busy=%b",
               name, cmd_valid, cmd_err, cmd_code, cmd_value, busy, v, e, c, val, b);
    end
  endtask

  task automatic send(input logic [7:0] d);
    rx_done = 1'b1;
    rx_data = d;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rx_done  = 1'b0;
    rx_data  = 8'h00;

    // "R" CR
    add(1'b1, 8'h52, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h0D, 1'b1, 1'b0, 2'd0, 14'd0, 1'b0);
    // "v1234" LF
    add(1'b1, 8'h76, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h31, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h32, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h34, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h0A, 1'b1, 1'b0, 2'd3, 14'd1234, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b0);
    // "V12345" CR: too many digits
    add(1'b1, 8'h56, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h31, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h32, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h33, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h34, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h35, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h0D, 1'b0, 1'b1, 2'd3, 14'd1234, 1'b0);
    // "X9" CR then "C" CR LF
    add(1'b1, 8'h58, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h39, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h0D, 1'b0, 1'b1, 2'd3, 14'd1234, 1'b0);
    add(1'b1, 8'h43, 1'b0, 1'b0, 2'd3, 14'd1234, 1'b1);
    add(1'b1, 8'h0D, 1'b1, 1'b0, 2'd2, 14'd0, 1'b0);
    add(1'b1, 8'h0A, 1'b0, 1'b0, 2'd2, 14'd0, 1'b0);
    // "S" CR, then "V" CR (missing operand)
    add(1'b1, 8'h53, 1'b0, 1'b0, 2'd2, 14'd0, 1'b1);
    add(1'b1, 8'h0D, 1'b1, 1'b0, 2'd1, 14'd0, 1'b0);
    add(1'b1, 8'h56, 1'b0, 1'b0, 2'd1, 14'd0, 1'b1);
    add(1'b1, 8'h0D, 1'b0, 1'b1, 2'd1, 14'd0, 1'b0);
    // "V0007" CR: leading zeros, four digits is fine
    add(1'b1, 8'h56, 1'b0, 1'b0, 2'd1, 14'd0, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd1, 14'd0, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd1, 14'd0, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd1, 14'd0, 1'b1);
    add(1'b1, 8'h37, 1'b0, 1'b0, 2'd1, 14'd0, 1'b1);
    add(1'b1, 8'h0D, 1'b1, 1'b0, 2'd3, 14'd7, 1'b0);
    // "V00000" CR: five digits with leading zeros
    add(1'b1, 8'h56, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h30, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h0D, 1'b0, 1'b1, 2'd3, 14'd7, 1'b0);
    // 'R' with bit7 set is invalid
    add(1'b1, 8'hD2, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h0D, 1'b0, 1'b1, 2'd3, 14'd7, 1'b0);
    // "c5" CR: digits only allowed after VALUE
    add(1'b1, 8'h63, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h35, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h0D, 1'b0, 1'b1, 2'd3, 14'd7, 1'b0);
    // "r", CR on the bus without strobe (ignored), then CR
    add(1'b1, 8'h72, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b0, 8'h0D, 1'b0, 1'b0, 2'd3, 14'd7, 1'b1);
    add(1'b1, 8'h0D, 1'b1, 1'b0, 2'd0, 14'd0, 1'b0);
    // "v9999" LF: maximum operand
    add(1'b1, 8'h76, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h39, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h39, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h39, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h39, 1'b0, 1'b0, 2'd0, 14'd0, 1'b1);
    add(1'b1, 8'h0A, 1'b1, 1'b0, 2'd3, 14'd9999, 1'b0);
    // Bare LF in IDLE, then a letter without strobe
    add(1'b1, 8'h0A, 1'b0, 1'b0, 2'd3, 14'd9999, 1'b0);
    add(1'b0, 8'h53, 1'b0, 1'b0, 2'd3, 14'd9999, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0, 2'd0, 14'd0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_release", 1'b0, 1'b0, 2'd0, 14'd0, 1'b0);

    // Table vectors, one per cycle, strobes back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      rx_done = vecs[i].dv;
      rx_data = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].v, vecs[i].e, vecs[i].c, vecs[i].val, vecs[i].b);
    end
    rx_done = 1'b0;

    // Reset in the middle of "V56": partial line is dropped.
    send(8'h56);
    send(8'h35);
    send(8'h36);
    check("mid_line_busy", 1'b0, 1'b0, 2'd3, 14'd9999, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst", 1'b0, 1'b0, 2'd0, 14'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h0D);
    check("cr_after_rst", 1'b0, 1'b0, 2'd0, 14'd0, 1'b0);
    @(posedge clk);
    #1;
    check("quiet_after_rst", 1'b0, 1'b0, 2'd0, 14'd0, 1'b0);

    // A complete line still parses normally after the reset.
    send(8'h53);
    send(8'h0D);
    check("stop_after_rst", 1'b1, 1'b0, 2'd1, 14'd0, 1'b0);
    @(posedge clk);
    #1;
    check("pulse_one_cycle", 1'b0, 1'b0, 2'd1, 14'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
